// File: rtl/step_ctrl_pkg.sv
// Shared types and default constants for the step clock controller.
package step_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } step_state_t;

    // 20 ms of key stability at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
    // 32 Hz auto-run rate at 50 MHz with RateSel = 0
    localparam int RATE_BASE_DEF       = 1_562_500;
    // wide enough for (RATE_BASE_DEF << 7) - 1
    localparam int DIV_W_DEF           = 28;

    // Counter width able to hold n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioning: 2-flop synchronizer followed by a stability
// counter. KeyAccept marks the cycle in which KeyLevel is about to toggle.
module key_debounce
    import step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic Reset,
    input  logic KeyIn,
    output logic KeySync,
    output logic KeyLevel,
    output logic KeyAccept
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             key_s1;
    logic             key_s2;
    logic [CNT_W-1:0] db_cnt;
    logic             key_level_q;
    logic             level_differs;

    // Synchronizer flops idle at the released (high) level.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
        end else begin
            key_s1 <= KeyIn;
            key_s2 <= key_s1;
        end
    end

    // The raw key is active-low; KeyLevel is active-high.
    assign level_differs = (~key_s2) != key_level_q;
    assign KeyAccept     = level_differs && (db_cnt == CNT_LAST);
    assign KeySync       = key_s2;
    assign KeyLevel      = key_level_q;

    // Count consecutive cycles of a differing level; toggle on the last one.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            db_cnt      <= '0;
            key_level_q <= 1'b0;
        end else if (!level_differs) begin
            db_cnt      <= '0;
        end else if (KeyAccept) begin
            db_cnt      <= '0;
            key_level_q <= ~key_level_q;
        end else begin
            db_cnt      <= db_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/step_clock_ctrl.sv
// Processor advance-strobe generator: single-step from a debounced key or
// auto-run from a programmable rate divider, plus a running step count.
module step_clock_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = DEBOUNCE_CYCLES_DEF,
    parameter int RATE_BASE_CYCLES = RATE_BASE_DEF,
    parameter int DIV_W            = DIV_W_DEF
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        KeyStep,
    input  logic        RunMode,
    input  logic [2:0]  RateSel,
    output logic        StepPulse,
    output logic [15:0] StepCount,
    output logic        KeyLevel,
    output logic        Running
);

    logic             key_sync;
    logic             key_accept;
    logic             run_s1;
    logic             run_s2;
    logic [1:0]       prime;
    logic             armed;
    step_state_t      state_q;
    step_state_t      state_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_term;
    logic             auto_pulse;
    logic             key_pulse;
    logic             pulse_next;
    logic             step_pulse_q;
    logic [15:0]      step_cnt_q;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk      (clk),
        .Reset    (Reset),
        .KeyIn    (KeyStep),
        .KeySync  (key_sync),
        .KeyLevel (KeyLevel),
        .KeyAccept(key_accept)
    );

    // RunMode synchronizer; the second flop is the exported Running level.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            run_s1 <= 1'b0;
            run_s2 <= 1'b0;
        end else begin
            run_s1 <= RunMode;
            run_s2 <= run_s1;
        end
    end

    assign Running = run_s2;

    // Arm single-step only after a genuine release has been seen, so a key
    // held through reset cannot fire. prime covers the synchronizer refill.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            prime <= 2'b00;
            armed <= 1'b0;
        end else begin
            prime <= {prime[0], 1'b1};
            if (prime[1] && key_sync)
                armed <= 1'b1;
        end
    end

    // Key FSM next-state: tracks press/release debounce phases.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (!key_sync)  state_d = PRESS_DB;
            PRESS_DB:   if (key_accept) state_d = HELD;
                        else if (key_sync) state_d = IDLE;
            HELD:       if (key_sync)   state_d = RELEASE_DB;
            RELEASE_DB: if (key_accept) state_d = IDLE;
                        else if (!key_sync) state_d = HELD;
            default:    state_d = IDLE;
        endcase
    end

    // Key FSM state register.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Terminal count follows RateSel immediately; a divider already past a
    // shortened terminal wraps on the next cycle via the >= compare.
    assign div_term   = (DIV_W'(RATE_BASE_CYCLES) << RateSel) - DIV_W'(1);
    assign auto_pulse = Running && (div_q >= div_term);
    // run_s1 is the Running value about to be loaded, so a press accepted
    // in the same cycle Running rises is dropped.
    assign key_pulse  = (state_q == PRESS_DB) && key_accept && armed
                        && !Running && !run_s1;
    assign pulse_next = auto_pulse || key_pulse;

    // Rate divider: held at zero while not running, so both Running edges
    // restart the period.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset)
            div_q <= '0;
        else if (!Running || auto_pulse)
            div_q <= '0;
        else
            div_q <= div_q + DIV_W'(1);
    end

    // Registered strobe and step counter update on the same edge.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            step_pulse_q <= 1'b0;
            step_cnt_q   <= 16'h0000;
        end else begin
            step_pulse_q <= pulse_next;
            if (pulse_next)
                step_cnt_q <= step_cnt_q + 16'd1;
        end
    end

    assign StepPulse = step_pulse_q;
    assign StepCount = step_cnt_q;

endmodule

// File: tb/tb_step_clock_ctrl.sv
// Directed bench for step_clock_ctrl with shortened debounce/rate constants.
module tb_step_clock_ctrl;

    logic        clk;
    logic        rst_n;
    logic        key_step;
    logic        run_mode;
    logic [2:0]  rate_sel;
    logic        step_pulse;
    logic [15:0] step_count;
    logic        key_level;
    logic        running;

    logic        key_w;
    logic        run_w;
    logic [2:0]  rate_w;
    logic        pulse_w;
    logic [15:0] count_w;
    logic        level_w;
    logic        running_w;

    int errors;
    int checks;
    int exp_count;

    step_clock_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .RATE_BASE_CYCLES(8),
        .DIV_W           (12)
    ) dut (
        .clk      (clk),
        .Reset    (rst_n),
        .KeyStep  (key_step),
        .RunMode  (run_mode),
        .RateSel  (rate_sel),
        .StepPulse(step_pulse),
        .StepCount(step_count),
        .KeyLevel (key_level),
        .Running  (running)
    );

    // Fast-rate instance: one pulse per clock, used to exercise the wrap.
    step_clock_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .RATE_BASE_CYCLES(1),
        .DIV_W           (8)
    ) dut_w (
        .clk      (clk),
        .Reset    (rst_n),
        .KeyStep  (key_w),
        .RunMode  (run_w),
        .RateSel  (rate_w),
        .StepPulse(pulse_w),
        .StepCount(count_w),
        .KeyLevel (level_w),
        .Running  (running_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int pulses;
        logic exp;
        rst_n = 1'b0; key_step = 1'b0; run_mode = 1'b0; rate_sel = 3'd0;
        key_w = 1'b1; run_w = 1'b0; rate_w = 3'd0;
        tick(3);
        checks++; if (step_pulse !== 1'b0) begin errors++; $display("FAIL rst_pulse got=%b exp=0", step_pulse); end
        checks++; if (step_count !== 16'h0000) begin errors++; $display("FAIL rst_count got=%h exp=0000", step_count); end
        checks++; if (key_level !== 1'b0) begin errors++; $display("FAIL rst_level got=%b exp=0", key_level); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL rst_running got=%b exp=0", running); end
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (step_pulse === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL held_at_reset_pulses got=%0d exp=0", pulses); end
        checks++; if (key_level !== 1'b1) begin errors++; $display("FAIL held_at_reset_level got=%b exp=1", key_level); end
        key_step = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (step_pulse === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL release_pulses got=%0d exp=0", pulses); end
        checks++; if (key_level !== 1'b0) begin errors++; $display("FAIL release_level got=%b exp=0", key_level); end
        key_step = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            exp = (i == 6);
            checks++;
            if (step_pulse !== exp) begin errors++; $display("FAIL repress_pulse cyc=%0d got=%b exp=%b", i, step_pulse, exp); end
            if (i == 6) key_step = 1'b1;
        end
        exp_count = 1;
        checks++; if (step_count !== 16'd1) begin errors++; $display("FAIL repress_count got=%0d exp=1", step_count); end
        tick(6);
    endtask

    task automatic test_single_step;
        logic exp_p, exp_l;
        key_step = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            tick(1);
            exp_p = (i == 6);
            exp_l = (i >= 6) && (i < 38);
            checks++;
            if (step_pulse !== exp_p) begin errors++; $display("FAIL step_pulse cyc=%0d got=%b exp=%b", i, step_pulse, exp_p); end
            checks++;
            if (key_level !== exp_l) begin errors++; $display("FAIL step_level cyc=%0d got=%b exp=%b", i, key_level, exp_l); end
            if (i == 30) key_step = 1'b1;
            if (i == 31) key_step = 1'b0;
            if (i == 32) key_step = 1'b1;
        end
        exp_count++;
        checks++; if (step_count !== 16'(exp_count)) begin errors++; $display("FAIL step_count got=%0d exp=%0d", step_count, exp_count); end
    endtask

    task automatic test_glitch;
        key_step = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            checks++;
            if (key_level !== 1'b0) begin errors++; $display("FAIL glitch_level cyc=%0d got=%b exp=0", i, key_level); end
            checks++;
            if (step_pulse !== 1'b0) begin errors++; $display("FAIL glitch_pulse cyc=%0d got=%b exp=0", i, step_pulse); end
            if (i == 3) key_step = 1'b1;
        end
        checks++; if (step_count !== 16'(exp_count)) begin errors++; $display("FAIL glitch_count got=%0d exp=%0d", step_count, exp_count); end
    endtask

    task automatic test_auto_run;
        logic exp;
        run_mode = 1'b1; rate_sel = 3'd0;
        for (int i = 1; i <= 140; i++) begin
            tick(1);
            if (i <= 3) begin
                checks++;
                if (running !== (i >= 2)) begin errors++; $display("FAIL auto_running cyc=%0d got=%b exp=%b", i, running, (i >= 2)); end
            end
            exp = (i == 10) || (i == 18) || (i == 26) || (i == 34) || (i == 66) ||
                  (i == 98) || (i == 119) || (i == 127);
            if (exp) exp_count++;
            checks++;
            if (step_pulse !== exp) begin errors++; $display("FAIL auto_pulse cyc=%0d got=%b exp=%b", i, step_pulse, exp); end
            if (i == 76) begin
                checks++;
                if (key_level !== 1'b1) begin errors++; $display("FAIL auto_key_level cyc=%0d got=%b exp=1", i, key_level); end
            end
            if (i == 88) begin
                checks++;
                if (key_level !== 1'b0) begin errors++; $display("FAIL auto_key_release cyc=%0d got=%b exp=0", i, key_level); end
            end
            if (i == 40)  rate_sel = 3'd2;
            if (i == 70)  key_step = 1'b0;
            if (i == 82)  key_step = 1'b1;
            if (i == 118) rate_sel = 3'd0;
            if (i == 130) run_mode = 1'b0;
        end
        checks++; if (step_count !== 16'(exp_count)) begin errors++; $display("FAIL auto_count got=%0d exp=%0d", step_count, exp_count); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL auto_stop_running got=%b exp=0", running); end
    endtask

    task automatic test_coincidence;
        logic exp;
        key_step = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            tick(1);
            exp = (i == 14) || (i == 22);
            if (exp) exp_count++;
            checks++;
            if (step_pulse !== exp) begin errors++; $display("FAIL coin_pulse cyc=%0d got=%b exp=%b", i, step_pulse, exp); end
            if (i == 5 || i == 6) begin
                checks++;
                if (running !== (i == 6)) begin errors++; $display("FAIL coin_running cyc=%0d got=%b exp=%b", i, running, (i == 6)); end
                checks++;
                if (key_level !== (i == 6)) begin errors++; $display("FAIL coin_level cyc=%0d got=%b exp=%b", i, key_level, (i == 6)); end
            end
            if (i == 4) run_mode = 1'b1;
        end
        run_mode = 1'b0;
        key_step = 1'b1;
        tick(12);
        checks++; if (step_count !== 16'(exp_count)) begin errors++; $display("FAIL coin_count got=%0d exp=%0d", step_count, exp_count); end
    endtask

    task automatic test_reset_mid;
        logic exp;
        run_mode = 1'b1; rate_sel = 3'd0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            exp = (i == 10);
            checks++;
            if (step_pulse !== exp) begin errors++; $display("FAIL pre_reset_pulse cyc=%0d got=%b exp=%b", i, step_pulse, exp); end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (step_pulse !== 1'b0) begin errors++; $display("FAIL async_rst_pulse got=%b exp=0", step_pulse); end
        checks++; if (step_count !== 16'h0000) begin errors++; $display("FAIL async_rst_count got=%h exp=0000", step_count); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL async_rst_running got=%b exp=0", running); end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        exp_count = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            exp = (i == 10);
            if (exp) exp_count++;
            checks++;
            if (step_pulse !== exp) begin errors++; $display("FAIL post_reset_pulse cyc=%0d got=%b exp=%b", i, step_pulse, exp); end
        end
        checks++; if (step_count !== 16'(exp_count)) begin errors++; $display("FAIL post_reset_count got=%0d exp=%0d", step_count, exp_count); end
        run_mode = 1'b0;
        tick(4);
    endtask

    task automatic test_wrap;
        run_w = 1'b1;
        tick(2);
        checks++; if (count_w !== 16'h0000) begin errors++; $display("FAIL wrap_start_count got=%h exp=0000", count_w); end
        checks++; if (running_w !== 1'b1) begin errors++; $display("FAIL wrap_running got=%b exp=1", running_w); end
        tick(1);
        checks++; if (count_w !== 16'h0001) begin errors++; $display("FAIL wrap_first_count got=%h exp=0001", count_w); end
        tick(65534);
        checks++; if (count_w !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff got=%h exp=ffff", count_w); end
        tick(1);
        checks++; if (count_w !== 16'h0000) begin errors++; $display("FAIL wrap_zero got=%h exp=0000", count_w); end
        checks++; if (pulse_w !== 1'b1) begin errors++; $display("FAIL wrap_pulse got=%b exp=1", pulse_w); end
        run_w = 1'b0;
        tick(3);
        checks++; if (pulse_w !== 1'b0) begin errors++; $display("FAIL wrap_stop_pulse got=%b exp=0", pulse_w); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        exp_count = 0;
        test_reset;
        test_single_step;
        test_glitch;
        test_auto_run;
        test_coincidence;
        test_reset_mid;
        test_wrap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
